// File: rtl/coin_return_timer_pkg.sv
// ============================================================================
// Module : coin_return_timer_pkg
// Brief  : Shared vending-machine definitions: denominations, widths, FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package coin_return_timer_pkg;

  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 31;
  localparam int kCoinValW  = 16;

  // Index 0 is the smallest denomination; values strictly ascending.
  localparam logic [kNumCoins*kCoinValW-1:0] kCoinValues = {16'd1000, 16'd500, 16'd100};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_DISPENSE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/coin_return_timer_coin_change_picker.sv
// ============================================================================
// Module : coin_change_picker
// Brief  : Combinational greedy pick of the largest coin not exceeding remaining.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_change_picker #(
  parameter int NUM_COINS  = 3,
  parameter int COIN_VAL_W = 16,
  parameter int TOTAL_BITS = 31,
  parameter logic [NUM_COINS*COIN_VAL_W-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100}
) (
  input  logic [TOTAL_BITS-1:0] i_remaining,
  output logic [NUM_COINS-1:0]  o_coin,
  output logic [TOTAL_BITS-1:0] o_value
);

  logic [NUM_COINS-1:0] w_fits;

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_fit
    assign w_fits[i] = i_remaining >= TOTAL_BITS'(COIN_VALUES[i*COIN_VAL_W +: COIN_VAL_W]);
  end

  // Ascending values make w_fits a thermometer code; its top set bit is the pick.
  assign o_coin = w_fits & ~(w_fits >> 1);

  always_comb begin
    o_value = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (o_coin[i]) begin
        o_value = o_value | TOTAL_BITS'(COIN_VALUES[i*COIN_VAL_W +: COIN_VAL_W]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/coin_return_timer.sv
// ============================================================================
// Module : coin_return_timer
// Brief  : Coin-return controller; inactivity auto-return when
//          COIN_RETURN_TIMEOUT_EN is defined, trigger-only return otherwise.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_return_timer
  import coin_return_timer_pkg::*;
#(
  parameter int NUM_COINS      = kNumCoins,
  parameter int NUM_ITEMS      = kNumItems,
  parameter int TOTAL_BITS     = kTotalBits,
  parameter int COIN_VAL_W     = kCoinValW,
  parameter logic [NUM_COINS*COIN_VAL_W-1:0] COIN_VALUES = kCoinValues,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_COINS-1:0]                    i_input_coin,
  input  logic [NUM_ITEMS-1:0]                    i_select_item,
  input  logic [NUM_ITEMS-1:0]                    i_item_available,
  input  logic                                    i_trigger_return,
  input  logic [TOTAL_BITS-1:0]                   i_current_total,
  output logic [NUM_COINS-1:0]                    o_return_coin,
  output logic                                    o_busy,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]     o_wait_time,
  output logic                                    o_return_done,
  output logic [TOTAL_BITS-1:0]                   o_residue
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]    TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TOTAL_BITS-1:0] MIN_COIN   = TOTAL_BITS'(COIN_VALUES[COIN_VAL_W-1:0]);

  state_t                r_state, w_state_nxt;
  logic                  r_pending, w_pending_nxt;
  logic [TOTAL_BITS-1:0] r_remaining, w_remaining_nxt;
  logic [NUM_COINS-1:0]  w_pick_coin;
  logic [TOTAL_BITS-1:0] w_pick_value;
  logic                  w_credit;
  logic                  w_coin_in;
  logic                  w_timeout;

  assign w_credit  = i_current_total >= MIN_COIN;
  assign w_coin_in = |i_input_coin;

  coin_change_picker #(
    .NUM_COINS   (NUM_COINS),
    .COIN_VAL_W  (COIN_VAL_W),
    .TOTAL_BITS  (TOTAL_BITS),
    .COIN_VALUES (COIN_VALUES)
  ) u_picker (
    .i_remaining (r_remaining),
    .o_coin      (w_pick_coin),
    .o_value     (w_pick_value)
  );

`ifdef COIN_RETURN_TIMEOUT_EN
  logic               w_activity;
  logic [TIMER_W-1:0] r_timer;

  assign w_activity  = w_coin_in || (|(i_select_item & i_item_available));
  assign w_timeout   = (r_timer == '0) && !w_activity;
  assign o_wait_time = r_timer;

  // Timer runs only while staying in COUNT, holds through DISPENSE, reloads otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= TIMER_LOAD;
    end else if (r_state == ST_COUNT && w_state_nxt == ST_COUNT) begin
      if (w_activity) begin
        r_timer <= TIMER_LOAD;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end else if (w_state_nxt != ST_DISPENSE) begin
      r_timer <= TIMER_LOAD;
    end
  end
`else
  logic w_unused_sel;

  assign w_unused_sel = ^{i_select_item, i_item_available};
  assign w_timeout    = 1'b0;
  assign o_wait_time  = TIMER_LOAD;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_remaining_nxt = r_remaining;
    o_return_coin   = '0;
    o_busy          = 1'b0;
    o_return_done   = 1'b0;
    o_residue       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_credit) begin
          w_state_nxt = ST_COUNT;
          if (i_trigger_return) w_pending_nxt = 1'b1;
        end else begin
          w_pending_nxt = 1'b0;
        end
      end
      ST_COUNT: begin
        if (!w_credit) begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 1'b0;
        end else if (!w_coin_in && (r_pending || i_trigger_return || w_timeout)) begin
          w_state_nxt     = ST_DISPENSE;
          w_pending_nxt   = 1'b0;
          w_remaining_nxt = i_current_total;
        end else if (i_trigger_return) begin
          // A coin this cycle defers the return; it fires on the first coin-free cycle.
          w_pending_nxt = 1'b1;
        end
      end
      ST_DISPENSE: begin
        o_busy = 1'b1;
        if (r_remaining < MIN_COIN) begin
          o_return_done = 1'b1;
          o_residue     = r_remaining;
          w_state_nxt   = ST_IDLE;
        end else begin
          o_return_coin   = w_pick_coin;
          w_remaining_nxt = r_remaining - w_pick_value;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_coin_return_timer.sv
// ============================================================================
// Module : tb_coin_return_timer
// Brief  : Directed scoreboard bench for coin_return_timer (both macro builds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coin_return_timer;

  typedef struct {
    int         cyc;
    logic [2:0] coin;
    logic       done;
    int         residue;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  input_coin;
  logic [3:0]  select_item;
  logic [3:0]  item_available;
  logic        trigger_return;
  logic [30:0] current_total;
  logic [2:0]  return_coin;
  logic        busy;
  logic [6:0]  wait_time;
  logic        return_done;
  logic [30:0] residue;

  int   cyc;
  int   n_cmp;
  int   n_err;
  int   t;
  ev_t  sb[$];

  coin_return_timer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_input_coin     (input_coin),
    .i_select_item    (select_item),
    .i_item_available (item_available),
    .i_trigger_return (trigger_return),
    .i_current_total  (current_total),
    .o_return_coin    (return_coin),
    .o_busy           (busy),
    .o_wait_time      (wait_time),
    .o_return_done    (return_done),
    .o_residue        (residue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] coin, input logic done, input int res);
    ev_t e;
    e.cyc = c; e.coin = coin; e.done = done; e.residue = res;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Scoreboard consumer: every dispensed coin or done pulse must match the head entry.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (return_coin !== 3'b000 || return_done !== 1'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_out", longint'({return_done, return_coin}), 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_coin", return_coin, e.coin);
        check("ev_done", return_done, e.done);
        check("ev_residue", residue, e.residue);
        check("ev_busy", busy, 1);
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0;
    reset_n = 1'b0; input_coin = '0; select_item = '0; item_available = '0;
    trigger_return = 1'b0; current_total = '0;
    step(3);
    check("rst_coin", return_coin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", return_done, 0);
    check("rst_residue", residue, 0);
    check("rst_wait", wait_time, 100);
    reset_n = 1'b1;
    step(2);

    // Trigger without credit is ignored
    current_total = 31'd50; trigger_return = 1'b1;
    step(1);
    trigger_return = 1'b0;
    step(3);
    check("nocredit_busy", busy, 0);

    // 1600 -> 1000, 500, 100, done residue 0
    current_total = 31'd1600;
    step(3);
    t = cyc;
    trigger_return = 1'b1;
    push(t+1, 3'b100, 1'b0, 0);
    push(t+2, 3'b010, 1'b0, 0);
    push(t+3, 3'b001, 1'b0, 0);
    push(t+4, 3'b000, 1'b1, 0);
    check("pre_entry_busy", busy, 0);
    step(1);
    trigger_return = 1'b0; current_total = '0;
    check("entry_busy", busy, 1);
    step(5);
    check("drain_1600", sb.size(), 0);
    check("idle_busy_1600", busy, 0);

    // Coin and trigger together: coin wins, 650 latched one cycle later
    current_total = 31'd550;
    step(2);
    t = cyc;
    trigger_return = 1'b1; input_coin = 3'b001;
    push(t+2, 3'b010, 1'b0, 0);
    push(t+3, 3'b001, 1'b0, 0);
    push(t+4, 3'b000, 1'b1, 50);
    step(1);
    trigger_return = 1'b0; input_coin = '0; current_total = 31'd650;
    check("coin_wins_busy", busy, 0);
    step(1);
    check("deferred_busy", busy, 1);
    current_total = 31'd50;
    step(5);
    check("drain_650", sb.size(), 0);

    // Reset on the second DISPENSE cycle aborts without a done pulse
    current_total = 31'd1600;
    step(3);
    t = cyc;
    trigger_return = 1'b1;
    push(t+1, 3'b100, 1'b0, 0);
    step(1);
    trigger_return = 1'b0; current_total = 31'd600;
    step(1);
    reset_n = 1'b0;
    #1;
    check("abort_coin", return_coin, 0);
    check("abort_busy", busy, 0);
    check("abort_done", return_done, 0);
    check("abort_residue", residue, 0);
    check("abort_wait", wait_time, 100);
    current_total = '0;
    step(2);
    reset_n = 1'b1;
    step(5);
    check("drain_abort", sb.size(), 0);
    check("abort_idle_busy", busy, 0);

`ifdef COIN_RETURN_TIMEOUT_EN
    // 300 with no activity: countdown 100..0 then three 100 coins
    current_total = 31'd300;
    step(1);
    check("wait_start", wait_time, 100);
    step(50);
    check("wait_mid", wait_time, 50);
    step(50);
    check("wait_zero", wait_time, 0);
    t = cyc;
    push(t+1, 3'b001, 1'b0, 0);
    push(t+2, 3'b001, 1'b0, 0);
    push(t+3, 3'b001, 1'b0, 0);
    push(t+4, 3'b000, 1'b1, 0);
    step(1);
    current_total = '0;
    step(5);
    check("drain_timeout", sb.size(), 0);

    // Coin at wait_time==5 reloads the timer; no dispense follows
    current_total = 31'd300;
    step(96);
    check("wait_5", wait_time, 5);
    input_coin = 3'b001;
    step(1);
    input_coin = '0; current_total = 31'd400;
    check("wait_reload", wait_time, 100);
    step(10);
    check("wait_after_reload", wait_time, 90);
    check("reload_busy", busy, 0);
    current_total = '0;
    step(2);
    check("wait_idle", wait_time, 100);
    check("drain_reload", sb.size(), 0);
`else
    // No timer: credit idles indefinitely until a trigger
    current_total = 31'd500;
    step(150);
    check("notimer_wait_a", wait_time, 100);
    check("notimer_busy_a", busy, 0);
    step(150);
    check("notimer_wait_b", wait_time, 100);
    check("notimer_busy_b", busy, 0);
    t = cyc;
    trigger_return = 1'b1;
    push(t+1, 3'b010, 1'b0, 0);
    push(t+2, 3'b000, 1'b1, 0);
    step(1);
    trigger_return = 1'b0; current_total = '0;
    step(4);
    check("drain_notimer", sb.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
